// File: rtl/ps2_receptor.sv
// PS/2 serial receiver: synchronizes and glitch-filters the PS/2 clock, deserializes
// 11-bit frames and emits dout with a one-cycle ready, parity_err or frame_err pulse.
module ps2_receptor #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       ready,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] DATA  = 2'b01;
  localparam logic [1:0] CHECK = 2'b10;

  logic                  c_s0, c_s1, d_s0, d_s1;
  logic [FILTER_LEN-1:0] filt_reg;
  logic                  filt_clk;
  logic                  fall_tick;

  logic [1:0]    state;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [9:0]    sr;

  // Filter register clears on reset, so the clock level must re-qualify before any edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_s0     <= 1'b0;
      c_s1     <= 1'b0;
      d_s0     <= 1'b0;
      d_s1     <= 1'b0;
      filt_reg <= '0;
      filt_clk <= 1'b0;
    end else begin
      c_s0     <= ps2c;
      c_s1     <= c_s0;
      d_s0     <= ps2d;
      d_s1     <= d_s0;
      filt_reg <= {filt_reg[FILTER_LEN-2:0], c_s1};
      if (&filt_reg)
        filt_clk <= 1'b1;
      else if (~|filt_reg)
        filt_clk <= 1'b0;
    end
  end

  // High in the cycle where filt_clk is about to drop from 1 to 0.
  assign fall_tick = filt_clk & ~|filt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      sr         <= '0;
      dout       <= '0;
      ready      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      ready      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (fall_tick && rx_en && !d_s1) begin
            bit_cnt <= '0;
            tmo_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (fall_tick) begin
            sr      <= {d_s1, sr[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
            tmo_cnt <= '0;
            if (bit_cnt == 4'd9)
              state <= CHECK;
          end else if (tmo_cnt == TMO_LAST) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        CHECK: begin
          // sr = {stop, parity, d7..d0}; stop-bit error outranks parity error.
          if (!sr[9])
            frame_err <= 1'b1;
          else if (!(^sr[8:0]))
            parity_err <= 1'b1;
          else begin
            dout  <= sr[7:0];
            ready <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_receptor.sv
// Bench for ps2_receptor: table vectors, hand-written corner sequences and random
// frames, all checked through a pulse scoreboard fed by a frame-level model.
module tb_ps2_receptor;

  localparam int FL = 8;
  localparam int TO = 300;
  localparam int H  = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2c, ps2d, rx_en;
  logic [7:0] dout;
  logic       ready, parity_err, frame_err;

  ps2_receptor #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .dout(dout), .ready(ready), .parity_err(parity_err), .frame_err(frame_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // exp entry: {check_latency, kind(1=ready,2=parity,3=frame), data}
  logic [10:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          fall_cyc = 0;
  int          pulse_cnt = 0;
  logic [7:0]  exp_dout = 8'h00;
  logic        prev_pulse = 1'b0;
  logic [7:0]  prev_dout = 8'h00;
  logic        break_seen = 1'b0;
  logic [7:0]  captured = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame-level reference: stop bit first, then odd parity over data+parity.
  function automatic logic [10:0] model(input logic [7:0] d, input logic p, input logic s);
    if (!s) return {1'b1, 2'd3, 8'h00};
    if ((($countones(d) + int'(p)) % 2) == 0) return {1'b1, 2'd2, 8'h00};
    return {1'b1, 2'd1, d};
  endfunction

  logic [10:0] e;
  int          kind, n, lat;
  always @(negedge clk) begin
    if (reset) begin
      prev_pulse = 1'b0;
      prev_dout  = dout;
    end else begin
      if (ready | parity_err | frame_err) begin
        pulse_cnt++;
        n = int'(ready) + int'(parity_err) + int'(frame_err);
        chk("pulse_onehot", n, 1);
        chk("pulse_single_cycle", prev_pulse, 0);
        kind = ready ? 1 : (parity_err ? 2 : 3);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got kind %0d want none (cycle %0d)", kind, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", kind, e[9:8]);
          if (ready) chk("dout_on_ready", dout, e[7:0]);
          if (e[10]) begin
            lat = cyc - fall_cyc;
            total++;
            if (lat < FL + 4 || lat > FL + 5) begin
              bad++;
              $display("FAIL strobe_latency: got %0d want %0d..%0d", lat, FL + 4, FL + 5);
            end
          end
        end
        if (ready) begin
          if (break_seen) captured = dout;
          break_seen = (dout == 8'hF0);
        end
      end
      if (dout !== prev_dout) chk("dout_changes_only_with_ready", ready, 1);
      prev_pulse = ready | parity_err | frame_err;
      prev_dout  = dout;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; data changes while the PS/2 clock is high.
  task automatic drive_bit(input logic b, input bit glitch);
    ps2d = b;
    if (glitch) begin
      repeat (20) @(negedge clk);
      ps2c = 1'b0;
      repeat (FL - 2) @(negedge clk);
      ps2c = 1'b1;
      repeat (H - 20 - (FL - 2)) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    ps2c = 1'b0;
    fall_cyc = cyc;
    repeat (H) @(negedge clk);
    ps2c = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int nbits, input int glitch_idx);
    for (int i = 0; i < nbits; i++) drive_bit(f[i], i == glitch_idx);
    ps2d = 1'b1;
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_missing_pulse: got none want %0d pending", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int g, input logic [10:0] ev, input string nm);
    exp_q.push_back(ev);
    if (ev[9:8] == 2'd1) exp_dout = ev[7:0];
    send_bits({s, p, d, 1'b0}, 11, g);
    drain(nm);
    chk({nm, "_dout"}, dout, exp_dout);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    int         glitch;
    logic [1:0] exp_kind;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t tbl[7];
  int   pc0;
  logic [7:0] rd;
  logic       rp, rs;
  int         rg;

  initial begin
    tbl[0] = '{8'h1C, 1'b0, 1'b1, -1, 2'd1, 8'h1C};
    tbl[1] = '{8'hF0, 1'b1, 1'b1, -1, 2'd1, 8'hF0};
    tbl[2] = '{8'h1C, 1'b0, 1'b1, -1, 2'd1, 8'h1C};
    tbl[3] = '{8'h1C, 1'b1, 1'b1, -1, 2'd2, 8'h1C};
    tbl[4] = '{8'h1C, 1'b0, 1'b0, -1, 2'd3, 8'h1C};
    tbl[5] = '{8'h1C, 1'b0, 1'b1,  3, 2'd1, 8'h1C};
    tbl[6] = '{8'h5A, 1'b1, 1'b1, -1, 2'd1, 8'h5A};

    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    rx_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {dout, ready, parity_err, frame_err}, 32'h0);
    #2 reset = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].d, tbl[i].p, tbl[i].s, tbl[i].glitch,
                 {1'b1, tbl[i].exp_kind, (tbl[i].exp_kind == 2'd1) ? tbl[i].d : 8'h00},
                 $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_dout_expected", i), dout, tbl[i].exp_dout);
      if (i == 2) chk("capture_after_break", captured, 8'h1C);
    end

    // Stall after start + 4 data bits; only the timeout can close this frame.
    exp_q.push_back({1'b0, 2'd3, 8'h00});
    send_bits({1'b1, 1'b0, 8'h77, 1'b0}, 5, -1);
    repeat (TO + 60) @(negedge clk);
    drain("timeout");
    chk("timeout_dout", dout, exp_dout);
    send_frame(8'h5A, 1'b1, 1'b1, -1, {1'b1, 2'd1, 8'h5A}, "after_timeout");

    // Frame while rx_en is low is ignored entirely.
    rx_en = 1'b0;
    pc0 = pulse_cnt;
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 11, -1);
    repeat (30) @(negedge clk);
    rx_en = 1'b1;
    chk("rx_en_low_no_pulse", pulse_cnt - pc0, 0);
    chk("rx_en_low_dout", dout, exp_dout);

    // Reset after 5 data bits, then a clean 0x29.
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 6, -1);
    #2 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("outputs_in_reset", {dout, ready, parity_err, frame_err}, 32'h0);
    end
    #2 reset = 1'b0;
    exp_dout   = 8'h00;
    break_seen = 1'b0;
    repeat (20) @(negedge clk);
    pc0 = pulse_cnt;
    send_frame(8'h29, 1'b0, 1'b1, -1, {1'b1, 2'd1, 8'h29}, "after_reset");
    chk("after_reset_one_pulse", pulse_cnt - pc0, 1);

    // Random back-to-back frames against the model.
    for (int i = 0; i < 25; i++) begin
      rd = 8'($urandom_range(0, 255));
      rp = ($urandom_range(0, 3) == 0) ? ^rd : ~^rd;
      rs = ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
      rg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1;
      send_frame(rd, rp, rs, rg, model(rd, rp, rs), $sformatf("rnd%0d", i));
    end

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(10 * 90000);
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_receptor.md
# ps2_receptor

PS/2 serial receiver that deserializes the keyboard's clock/data lines into bytes and presents each byte with a one-cycle `ready` strobe. It sits directly upstream of the break-code capture stage (`ready`/`dout` feed that stage's `ready`/`datain`). It also handles line synchronization, glitch filtering, odd-parity and stop-bit checking, and inter-bit timeout recovery.

## Interface
Parameters:
- `FILTER_LEN`, default 8: consecutive equal samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, default 10000: maximum `clk` cycles between PS/2 falling edges inside a frame. 200 µs at 50 MHz.

Ports:
- `clk`  in  1  system clock. All logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high. Returns every register to its reset value.
- `ps2c`  in  1  raw PS/2 clock pin, asynchronous to `clk`.
- `ps2d`  in  1  raw PS/2 data pin, asynchronous to `clk`.
- `rx_en`  in  1  when high, a new frame may start. Has no effect on a frame already in progress.
- `dout`  out  8  last correctly received byte. Reset 0x00.
- `ready`  out  1  one-cycle pulse: `dout` has just been updated with a new byte. Reset 0.
- `parity_err`  out  1  one-cycle pulse: frame rejected, parity not odd. Reset 0.
- `frame_err`  out  1  one-cycle pulse: frame rejected because the stop bit was 0 or the timeout expired. Reset 0.

## Operation
- **Input path:** `ps2c` and `ps2d` each pass through a 2-flop synchronizer.
  - A `FILTER_LEN`-bit shift register samples the synchronized `ps2c`.
  - The filtered clock goes to 0 only when the register is all 0s, goes to 1 only when it is all 1s, and holds otherwise.
  - `fall_tick` is a one-cycle pulse on each 1→0 transition of the filtered clock.
- **Frame format:** 11 bits, each sampled from synchronized `ps2d` at `fall_tick`, in this order:
  - start bit = 0
  - d0..d7, LSB first
  - parity bit, odd: the XOR of d0..d7 and the parity bit must equal 1
  - stop bit = 1
- **IDLE:** on `fall_tick` with `rx_en`=1 and `ps2d`=0, clear the bit counter and the timeout counter, then go to DATA.
  - If the start bit samples as 1, stay in IDLE with no error pulse.
  - If `rx_en`=0, ignore the edge.
- **DATA:** on each `fall_tick`, shift the `ps2d` sample into a 10-bit shift register, right-shift so bits arrive LSB first. Increment the bit counter and clear the timeout counter.
  - After the 10th sample (the stop bit), go to CHECK.
  - If the timeout counter reaches `TIMEOUT_CYCLES` without a `fall_tick`, pulse `frame_err` and go to IDLE.
- **CHECK:** exactly one cycle, then IDLE. Exactly one of the following happens, in this priority order:
  1. Stop bit = 0: `frame_err` pulse, `dout` unchanged.
  2. Parity is not odd: `parity_err` pulse, `dout` unchanged.
  3. Otherwise: load `dout` with d7..d0 and pulse `ready`.
- **Outputs:** all outputs are registered. `ready`, `parity_err` and `frame_err` are never high simultaneously and never high for two consecutive cycles.
- **Unused state encoding:** the state register is 2 bits; the unused code returns to IDLE on the next cycle.
- **Reset mid-frame:** the partial frame is discarded. The next frame is received only after a new start bit, and only once the filter has re-qualified the clock level.

## Timing
- **Synchronizer:** 2 cycles.
- **Filter:** `FILTER_LEN` cycles of stable level.
- **Edge detect:** `fall_tick` occurs `FILTER_LEN`+2 or `FILTER_LEN`+3 cycles after the `ps2c` pin falls, depending on phase.
- **Latency to strobe:** `ready`, `parity_err` or `frame_err` goes high exactly 2 cycles after the `fall_tick` of the stop bit: the first cycle registers the transition into CHECK, the second registers the output.
- **Sampling point:** `ps2d` is sampled on the same cycle as `fall_tick`. The PS/2 data-valid window (≥5 µs around the falling edge) makes the skew of a few cycles irrelevant.
- **`dout` stability:** `dout` changes only on the cycle that `ready` rises, and holds until the next `ready`.
- **Back-to-back frames:** a start bit arriving at any time after CHECK is accepted; there is no minimum idle gap beyond the filter delay.
- **Reset priority:** `reset` asserted overrides any simultaneous `fall_tick` or timeout.

## Test plan
- Valid frame for 0x1C (bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 40 µs PS/2 clock period → `ready` is a single-cycle pulse, `dout`=0x1C, no error pulses.
- Sequence F0 (parity 1), then 1C → two `ready` pulses, `dout`=0xF0 then 0x1C. Feeding these into the downstream capture stage yields 0x1C.
- 0x1C sent with parity 1 → `parity_err` pulse only, `dout` stays at its previous value, `ready` stays 0.
- Valid data with stop bit 0 → `frame_err` pulse, `dout` unchanged. Then stall after 4 data bits for more than `TIMEOUT_CYCLES` → `frame_err` pulse. A subsequent 0x5A with parity 1 → `ready`, `dout`=0x5A.
- Glitch: `ps2c` low for `FILTER_LEN`−2 cycles mid-bit → no extra bit counted. The frame still decodes correctly as 0x1C.
- Assert `reset` after 5 data bits, release it, then send 0x29 with parity 0 → all outputs 0 during reset. Exactly one `ready` with `dout`=0x29. Also drop `rx_en` to 0 before a frame → no output for that frame.
